// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // IDLE: nothing outstanding, REQ: request presented, WAIT: accepted, awaiting response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer. Entry 0 is always the head so the outputs come
// straight from flops; a pop shifts entry 1 down. Flush wins over push/pop.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t e0_r, e0_s, e1_r, e1_s;
    logic         v0_r, v0_s, v1_r, v1_s;
    logic         pop_s;

    assign pop_s = pop & v0_r;

    // Next-state of the two slots: flush, then shift on pop, then fill first free slot
    always_comb begin
        e0_s = e0_r;
        e1_s = e1_r;
        v0_s = v0_r;
        v1_s = v1_r;
        if (flush) begin
            v0_s = 1'b0;
            v1_s = 1'b0;
        end else begin
            if (pop_s) begin
                e0_s = e1_r;
                v0_s = v1_r;
                v1_s = 1'b0;
            end else begin
            end
            if (push) begin
                if (!v0_s) begin
                    e0_s = push_data;
                    v0_s = 1'b1;
                end else if (!v1_s) begin
                    e1_s = push_data;
                    v1_s = 1'b1;
                end else begin
                end
            end else begin
            end
        end
    end

    // Slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_r <= '0;
            e1_r <= '0;
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            e0_r <= e0_s;
            e1_r <= e1_s;
            v0_r <= v0_s;
            v1_r <= v1_s;
        end
    end

    assign head  = e0_r;
    assign count = {v1_r, v0_r & ~v1_r};
    assign full  = v1_r;
    assign empty = ~v0_r;

    fetch_buf_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .full  (full)
    );

endmodule

// File: rtl/fetch_buf_chk.sv
// Property checker for the fetch buffer: a push must never land on a full
// buffer unless a pop or flush frees a slot in the same cycle.
module fetch_buf_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic flush,
    input logic full
);

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush))
        else $error("fetch_buf overflow: push into full buffer");

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// buffers up to two returned instructions and squashes wrong-path fetches
// after a redirect.
module pc_fetch_unit #(
    parameter int                 XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);
    import fetch_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(3'd4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(2'd3));

    fetch_state_e    state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s, addr_r, addr_s;
    logic            kill_r, kill_s, req_valid_r, req_valid_s;
    logic            push_s, pop_s, flush_s, accept_s, credit_s;
    logic [1:0]      count_s, occ_next_s;
    logic            full_s, empty_s;
    fetch_entry_t    push_data_s, head_s;

    assign pop_s       = ~empty_s & if_ready;
    assign accept_s    = req_valid_r & imem_req_ready;
    assign push_data_s = '{pc: addr_r, instr: imem_rsp_data};

    // FSM next state, PC sequencing, kill tracking and credit check
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        addr_s      = addr_r;
        kill_s      = kill_r;
        req_valid_s = req_valid_r;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        credit_s    = 1'b0;
        occ_next_s  = count_s - {1'b0, pop_s};
        if (redirect_valid) begin
            // Redirect beats any pop, push or response in the same cycle
            pc_s    = redirect_pc & ALIGN_MASK;
            flush_s = 1'b1;
            case (state_r)
                REQ: begin
                    kill_s = 1'b1;
                    if (accept_s) begin
                        state_s     = WAIT;
                        req_valid_s = 1'b0;
                    end else begin
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        // Response consumed right now, nothing left to kill
                        kill_s  = 1'b0;
                        state_s = IDLE;
                    end else begin
                        kill_s = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end else begin
            case (state_r)
                IDLE: begin
                    credit_s = ~full_s | pop_s;
                    if (credit_s) begin
                        state_s     = REQ;
                        req_valid_s = 1'b1;
                        addr_s      = pc_r;
                        pc_s        = pc_r + PC_STEP;
                    end else begin
                    end
                end
                REQ: begin
                    if (accept_s) begin
                        state_s     = WAIT;
                        req_valid_s = 1'b0;
                    end else begin
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        push_s     = ~kill_r;
                        kill_s     = 1'b0;
                        occ_next_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
                        credit_s   = (occ_next_s < 2'd2);
                        if (credit_s) begin
                            state_s     = REQ;
                            req_valid_s = 1'b1;
                            addr_s      = pc_r;
                            pc_s        = pc_r + PC_STEP;
                        end else begin
                            state_s = IDLE;
                        end
                    end else begin
                    end
                end
                default: begin
                    state_s     = IDLE;
                    req_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State, PC, kill and registered request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            pc_r        <= RESET_PC;
            addr_r      <= '0;
            kill_r      <= 1'b0;
            req_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            addr_r      <= addr_s;
            kill_r      <= kill_s;
            req_valid_r <= req_valid_s;
        end
    end

    fetch_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (flush_s),
        .push_data (push_data_s),
        .head      (head_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign imem_req_valid = req_valid_r;
    assign imem_addr      = addr_r;
    assign if_valid       = ~empty_s;
    assign if_pc          = head_s.pc;
    assign if_instr       = head_s.instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: table-driven startup check, directed corner
// sequences and a randomized run against a program-order reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] OFF2 = 32'hFFFF_FFF8;

    logic        clk, rst_n, redirect_valid, imem_req_ready, imem_rsp_valid, if_ready;
    logic [31:0] redirect_pc, imem_rsp_data;
    logic        imem_req_valid, if_valid, imem_req_valid2, if_valid2;
    logic [31:0] imem_addr, if_pc, if_instr, imem_addr2, if_pc2, if_instr2;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr));

    // Same stimulus, different reset PC: exercises the wrap-around at the top of memory
    pc_fetch_unit #(.XLEN(32), .RESET_PC(OFF2)) dut2 (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr2),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid2), .if_ready(if_ready), .if_pc(if_pc2), .if_instr(if_instr2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0, n_bad = 0, n_pops = 0;
    logic [31:0] exp_del, exp_req;
    logic [31:0] pop_q[$], req_q[$];
    logic        pend, rand_lat, last_acc;
    logic [31:0] pend_addr, last_acc_addr;
    int          pend_cnt, lat_cfg;

    typedef struct {
        logic        if_rdy;
        logic        mem_rdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a << 8) | 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock: model checks before/after the edge, then the memory responder
    task automatic tick();
        logic p_rst, p_rv, p_rdy, p_pop, p_redir;
        logic [31:0] p_addr, tgt;
        p_rst = rst_n; p_rv = imem_req_valid; p_rdy = imem_req_ready; p_addr = imem_addr;
        p_pop = if_valid && if_ready; p_redir = redirect_valid;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (p_rst) begin
            if (p_pop && !p_redir) begin
                chk("pop_pc", if_pc, exp_del);
                chk("pop_instr", if_instr, imem_word(exp_del));
                pop_q.push_back(if_pc);
                n_pops++;
                exp_del = exp_del + 32'd4;
            end
            if (p_redir) begin
                exp_del = tgt;
                exp_req = tgt;
            end
        end
        @(posedge clk);
        #1;
        last_acc = p_rst && p_rv && p_rdy;
        last_acc_addr = p_addr;
        if (p_rst && rst_n) begin
            if (imem_req_valid && !p_rv) begin
                chk("req_addr", imem_addr, exp_req);
                req_q.push_back(imem_addr);
                exp_req = exp_req + 32'd4;
            end
            if (p_rv && !p_rdy) begin
                chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
                chk("req_hold_addr", imem_addr, p_addr);
            end
            if (p_redir) chk("redirect_clears_if_valid", 32'(if_valid), 32'd0);
        end
        imem_rsp_valid = 1'b0;
        if (last_acc) begin
            pend = 1'b1;
            pend_addr = p_addr;
            pend_cnt = rand_lat ? int'($urandom_range(0, 2)) : lat_cfg;
        end
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = imem_word(pend_addr);
                pend = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic model_reset();
        pend = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        exp_del = 32'd0; exp_req = 32'd0;
        pop_q.delete(); req_q.delete();
        lat_cfg = 0; rand_lat = 1'b0;
        if_ready = 1'b1; imem_req_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int bound);
        int k = 0;
        while (pop_q.size() < n && k < bound) begin
            tick();
            k++;
        end
        chk("pop_timeout", 32'(pop_q.size() >= n), 32'd1);
    endtask

    function automatic logic [31:0] q0(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic found;
        //          if_rdy mem_rdy rv    addr          iv    ipc
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h4};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0008, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h8};

        // Reset state and best-case startup timing
        rst_n = 1'b0; redirect_pc = 32'd0; imem_rsp_data = 32'd0;
        model_reset();
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_addr2", imem_addr2, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if_ready = vecs[i].if_rdy;
            imem_req_ready = vecs[i].mem_rdy;
            tick();
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].rv));
            chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].iv));
            chk($sformatf("vec%0d_req_valid2", i), 32'(imem_req_valid2), 32'(vecs[i].rv));
            chk($sformatf("vec%0d_addr2", i), imem_addr2, vecs[i].addr + OFF2);
            chk($sformatf("vec%0d_if_valid2", i), 32'(if_valid2), 32'(vecs[i].iv));
            if (vecs[i].iv) begin
                chk($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].ipc);
                chk($sformatf("vec%0d_if_pc_wrap", i), if_pc2, vecs[i].ipc + OFF2);
                chk($sformatf("vec%0d_if_instr2", i), if_instr2, imem_word(vecs[i].ipc));
            end
        end

        // Backpressure: decode stalled, exactly two fetches then none
        do_reset();
        if_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bp_req_count", 32'(req_q.size()), 32'd2);
        chk("bp_if_valid", 32'(if_valid), 32'd1);
        chk("bp_head_pc", if_pc, 32'd0);
        if_ready = 1'b1;
        wait_pops(3, 40);
        chk("bp_pop0", q0(pop_q, 0), 32'h0);
        chk("bp_pop1", q0(pop_q, 1), 32'h4);
        chk("bp_pop2", q0(pop_q, 2), 32'h8);

        // Redirect while the request for 0x8 is outstanding
        do_reset();
        lat_cfg = 1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = last_acc && (last_acc_addr == 32'h8);
        end
        chk("wait_find_acc8", 32'(found), 32'd1);
        req_q.delete(); pop_q.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        wait_pops(1, 30);
        chk("wait_next_req", q0(req_q, 0), 32'h100);
        chk("wait_next_pop", q0(pop_q, 0), 32'h100);

        // Redirects while a request is stalled; last one wins, low bits dropped
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            found = imem_req_valid && (imem_addr == 32'h8);
        end
        chk("req_find_8", 32'(found), 32'd1);
        imem_req_ready = 1'b0;
        req_q.delete(); pop_q.delete();
        for (int k = 0; k < 3; k++) begin
            redirect_valid = (k < 2);
            redirect_pc = (k == 0) ? 32'h0000_0300 : 32'h0000_0203;
            tick();
            chk("req_stall_valid", 32'(imem_req_valid), 32'd1);
            chk("req_stall_addr", imem_addr, 32'h8);
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        wait_pops(1, 30);
        chk("req_next_req", q0(req_q, 0), 32'h200);
        chk("req_next_pop", q0(pop_q, 0), 32'h200);

        // Reset mid-operation, stale response after release must be ignored
        do_reset();
        if_ready = 1'b0; lat_cfg = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            found = if_valid && imem_req_valid;
        end
        chk("mid_find_busy", 32'(found), 32'd1);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_addr", imem_addr, 32'd0);
        chk("mid_if_valid", 32'(if_valid), 32'd0);
        chk("mid_if_pc", if_pc, 32'd0);
        chk("mid_if_instr", if_instr, 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        wait_pops(2, 30);
        chk("mid_pop0", q0(pop_q, 0), 32'h0);
        chk("mid_pop1", q0(pop_q, 1), 32'h4);

        // Randomized traffic against the program-order model
        do_reset();
        rand_lat = 1'b1;
        n_pops = 0;
        for (int k = 0; k < 3000; k++) begin
            if_ready = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : ($urandom & 32'h0000_FFFF);
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 32'(n_pops >= 150), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
